// File: rtl/ysyx_25030085_rf_wb_sched_pkg.sv
// Shared widths and requester ids for the regfile writeback scheduler.
package ysyx_25030085_rf_pkg;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LSU = 1'b1
    } req_id_e;
endpackage

// File: rtl/ysyx_25030085_rf_wb_sched_if.sv
// Issue, writeback-request and regfile write-port bundle around the scheduler.
interface ysyx_25030085_rf_wb_sched_if
    import ysyx_25030085_rf_pkg::*;
();
    logic            issue_valid;
    logic            issue_ready;
    logic [AW-1:0]   issue_rs1;
    logic [AW-1:0]   issue_rs2;
    logic [AW-1:0]   issue_rd;
    logic            issue_wen;
    logic            alu_valid;
    logic            alu_ready;
    logic [AW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            lsu_valid;
    logic            lsu_ready;
    logic [AW-1:0]   lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic            rf_we;
    logic [AW-1:0]   rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [NREG-1:0] pending;

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_wen,
        output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        input  issue_ready, alu_ready, lsu_ready,
        input  rf_we, rf_waddr, rf_wdata, pending
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_wen,
        input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        output issue_ready, alu_ready, lsu_ready,
        output rf_we, rf_waddr, rf_wdata, pending
    );
endinterface

// File: rtl/ysyx_25030085_rf_wb_sched_rr_arb2.sv
// Two-way round-robin arbiter; requester 0 is the ALU, requester 1 the LSU.
module ysyx_25030085_rr_arb2
    import ysyx_25030085_rf_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic valid0,
    input  logic valid1,
    output logic grant0,
    output logic grant1
);
    req_id_e rr_last;
    logic    conflict;

    assign conflict = valid0 & valid1;
    // On a conflict the side that did not win the previous conflict goes first.
    assign grant0   = valid0 & (!valid1 | (rr_last == REQ_LSU));
    assign grant1   = valid1 & (!valid0 | (rr_last == REQ_ALU));

    always_ff @(posedge clk) begin
        if (!rst)
            rr_last <= REQ_ALU;
        else if (conflict)
            rr_last <= grant0 ? REQ_ALU : REQ_LSU;
    end
endmodule

// File: rtl/ysyx_25030085_rf_wb_sched.sv
// Writeback arbiter + RAW/WAW scoreboard in front of the single regfile write port.
module ysyx_25030085_rf_wb_sched
    import ysyx_25030085_rf_pkg::*;
(
    input logic                          clk,
    input logic                          rst,
    ysyx_25030085_rf_wb_sched_if.slave   bus
);
    logic            grant_alu, grant_lsu, wb_any;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            rf_we_q;
    logic [AW-1:0]   rf_waddr_q;
    logic [XLEN-1:0] rf_wdata_q;
    logic [NREG-1:0] pend_q, pend_nxt;
    logic            issue_ready, set_fire;

    ysyx_25030085_rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .valid0 (bus.alu_valid),
        .valid1 (bus.lsu_valid),
        .grant0 (grant_alu),
        .grant1 (grant_lsu)
    );

    assign wb_any  = grant_alu | grant_lsu;
    assign wb_rd   = grant_lsu ? bus.lsu_rd   : bus.alu_rd;
    assign wb_data = grant_lsu ? bus.lsu_data : bus.alu_data;

    // No bypass: a consumer waits until the regfile write edge has passed.
    assign issue_ready = !(pend_q[bus.issue_rs1] | pend_q[bus.issue_rs2] |
                           (bus.issue_wen & pend_q[bus.issue_rd]));
    assign set_fire    = bus.issue_valid & issue_ready & bus.issue_wen &
                         (bus.issue_rd != '0);

    // Clear first so a same-edge set of the same register wins.
    always_comb begin
        pend_nxt = pend_q;
        if (rf_we_q)
            pend_nxt[rf_waddr_q] = 1'b0;
        if (set_fire)
            pend_nxt[bus.issue_rd] = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            pend_q     <= '0;
        end else begin
            rf_we_q <= wb_any && (wb_rd != '0);
            if (wb_any) begin
                rf_waddr_q <= wb_rd;
                rf_wdata_q <= wb_data;
            end
            pend_q <= pend_nxt;
        end
    end

    assign bus.alu_ready   = grant_alu;
    assign bus.lsu_ready   = grant_lsu;
    assign bus.issue_ready = issue_ready;
    assign bus.rf_we       = rf_we_q;
    assign bus.rf_waddr    = rf_waddr_q;
    assign bus.rf_wdata    = rf_wdata_q;
    assign bus.pending     = pend_q;
endmodule

// File: tb/tb_ysyx_25030085_rf_wb_sched.sv
// Directed vector table, reset corner cases and a randomized run against a reference model.
module tb_ysyx_25030085_rf_wb_sched;
    import ysyx_25030085_rf_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ysyx_25030085_rf_wb_sched_if bus();
    ysyx_25030085_rf_wb_sched dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic av; logic [4:0] ard; logic [31:0] adata;
        logic lv; logic [4:0] lrd; logic [31:0] ldata;
        logic iv; logic wen; logic [4:0] rs1, rs2, rd;
        logic ear, elr, eir, ewe;
        logic [4:0] ewaddr; logic [31:0] ewdata; logic [31:0] epend;
    } vec_t;

    vec_t tbl[22];

    function automatic vec_t mk(input logic av, input int ard, input logic [31:0] adata,
                                input logic lv, input int lrd, input logic [31:0] ldata,
                                input logic iv, input logic wen, input int rs1, input int rs2,
                                input int rd, input logic ear, input logic elr, input logic eir,
                                input logic ewe, input int ewaddr, input logic [31:0] ewdata,
                                input logic [31:0] epend);
        vec_t v;
        v.av = av; v.ard = ard[4:0]; v.adata = adata;
        v.lv = lv; v.lrd = lrd[4:0]; v.ldata = ldata;
        v.iv = iv; v.wen = wen; v.rs1 = rs1[4:0]; v.rs2 = rs2[4:0]; v.rd = rd[4:0];
        v.ear = ear; v.elr = elr; v.eir = eir; v.ewe = ewe;
        v.ewaddr = ewaddr[4:0]; v.ewdata = ewdata; v.epend = epend;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adata,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ldata,
                         input logic iv, input logic wen, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd);
        bus.alu_valid = av;  bus.alu_rd = ard;  bus.alu_data = adata;
        bus.lsu_valid = lv;  bus.lsu_rd = lrd;  bus.lsu_data = ldata;
        bus.issue_valid = iv; bus.issue_wen = wen;
        bus.issue_rs1 = rs1; bus.issue_rs2 = rs2; bus.issue_rd = rd;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Reference model: register-level pending set, last conflict winner, write-port contents.
    bit [31:0] m_pend;
    bit        m_lsu_last;
    bit        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    task automatic model_reset();
        m_pend = '0; m_lsu_last = 1'b0; m_we = 1'b0; m_waddr = '0; m_wdata = '0;
    endtask

    task automatic model_cycle(output bit ga, output bit gl);
        bit eir;
        bit [31:0] np;
        ga  = bus.alu_valid && (!bus.lsu_valid || m_lsu_last);
        gl  = bus.lsu_valid && (!bus.alu_valid || !m_lsu_last);
        eir = !(m_pend[bus.issue_rs1] || m_pend[bus.issue_rs2] ||
                (bus.issue_wen && m_pend[bus.issue_rd]));
        chk("rnd_alu_ready", {31'b0, bus.alu_ready}, {31'b0, ga});
        chk("rnd_lsu_ready", {31'b0, bus.lsu_ready}, {31'b0, gl});
        chk("rnd_issue_ready", {31'b0, bus.issue_ready}, {31'b0, eir});
        chk("rnd_rf_we", {31'b0, bus.rf_we}, {31'b0, m_we});
        chk("rnd_pending", bus.pending, m_pend);
        if (m_we) begin
            chk("rnd_rf_waddr", {27'b0, bus.rf_waddr}, {27'b0, m_waddr});
            chk("rnd_rf_wdata", bus.rf_wdata, m_wdata);
        end
        np = m_pend;
        if (m_we) np[m_waddr] = 1'b0;
        if (bus.issue_valid && eir && bus.issue_wen && bus.issue_rd != 0) np[bus.issue_rd] = 1'b1;
        np[0] = 1'b0;
        m_pend = np;
        m_we = 1'b0;
        if (ga) begin m_we = (bus.alu_rd != 0); m_waddr = bus.alu_rd; m_wdata = bus.alu_data; end
        if (gl) begin m_we = (bus.lsu_rd != 0); m_waddr = bus.lsu_rd; m_wdata = bus.lsu_data; end
        if (bus.alu_valid && bus.lsu_valid) m_lsu_last = gl;
    endtask

    initial begin
        bit ga, gl;
        bit a_hold, l_hold;
        tbl[0]  = mk(1,5,32'h12345678, 0,0,0,            0,0,0,0,0, 1,0,1, 0,0,0,            0);
        tbl[1]  = mk(0,0,0,            0,0,0,            0,0,0,0,0, 0,0,1, 1,5,32'h12345678, 0);
        tbl[2]  = mk(0,0,0,            0,0,0,            0,0,0,0,0, 0,0,1, 0,0,0,            0);
        tbl[3]  = mk(0,0,0,            0,0,0,            1,1,0,0,7, 0,0,1, 0,0,0,            0);
        tbl[4]  = mk(0,0,0,            0,0,0,            1,0,7,0,0, 0,0,0, 0,0,0,            32'h80);
        tbl[5]  = mk(0,0,0,            0,0,0,            1,0,7,0,0, 0,0,0, 0,0,0,            32'h80);
        tbl[6]  = mk(0,0,0,            1,7,32'hDEADBEEF, 1,0,7,0,0, 0,1,0, 0,0,0,            32'h80);
        tbl[7]  = mk(0,0,0,            0,0,0,            1,0,7,0,0, 0,0,0, 1,7,32'hDEADBEEF, 32'h80);
        tbl[8]  = mk(0,0,0,            0,0,0,            1,0,7,0,0, 0,0,1, 0,0,0,            0);
        tbl[9]  = mk(1,1,32'h11,       1,2,32'h22,       0,0,0,0,0, 0,1,1, 0,0,0,            0);
        tbl[10] = mk(1,1,32'h11,       1,2,32'h23,       0,0,0,0,0, 1,0,1, 1,2,32'h22,       0);
        tbl[11] = mk(1,1,32'h12,       1,2,32'h23,       0,0,0,0,0, 0,1,1, 1,1,32'h11,       0);
        tbl[12] = mk(0,0,0,            0,0,0,            0,0,0,0,0, 0,0,1, 1,2,32'h23,       0);
        tbl[13] = mk(0,0,0,            0,0,0,            0,0,0,0,0, 0,0,1, 0,0,0,            0);
        tbl[14] = mk(1,0,32'h55,       0,0,0,            0,0,0,0,0, 1,0,1, 0,0,0,            0);
        tbl[15] = mk(0,0,0,            0,0,0,            0,0,0,0,0, 0,0,1, 0,0,0,            0);
        tbl[16] = mk(0,0,0,            1,3,32'h33,       0,0,0,0,0, 0,1,1, 0,0,0,            0);
        tbl[17] = mk(0,0,0,            0,0,0,            1,1,0,0,3, 0,0,1, 1,3,32'h33,       0);
        tbl[18] = mk(0,0,0,            0,0,0,            1,1,0,0,3, 0,0,0, 0,0,0,            32'h8);
        tbl[19] = mk(0,0,0,            1,3,32'h44,       1,1,0,0,3, 0,1,0, 0,0,0,            32'h8);
        tbl[20] = mk(0,0,0,            0,0,0,            1,1,0,0,3, 0,0,0, 1,3,32'h44,       32'h8);
        tbl[21] = mk(0,0,0,            0,0,0,            0,1,0,0,3, 0,0,1, 0,0,0,            0);

        // Reset held for two cycles with everything idle.
        idle();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 9, 4, 6);
        #1;
        chk("rst_rf_we", {31'b0, bus.rf_we}, 32'd0);
        chk("rst_rf_waddr", {27'b0, bus.rf_waddr}, 32'd0);
        chk("rst_rf_wdata", bus.rf_wdata, 32'd0);
        chk("rst_pending", bus.pending, 32'd0);
        chk("rst_issue_ready", {31'b0, bus.issue_ready}, 32'd1);
        rst = 1'b1;

        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            drive(tbl[i].av, tbl[i].ard, tbl[i].adata, tbl[i].lv, tbl[i].lrd, tbl[i].ldata,
                  tbl[i].iv, tbl[i].wen, tbl[i].rs1, tbl[i].rs2, tbl[i].rd);
            #1;
            chk($sformatf("vec%0d_alu_ready", i), {31'b0, bus.alu_ready}, {31'b0, tbl[i].ear});
            chk($sformatf("vec%0d_lsu_ready", i), {31'b0, bus.lsu_ready}, {31'b0, tbl[i].elr});
            chk($sformatf("vec%0d_issue_ready", i), {31'b0, bus.issue_ready}, {31'b0, tbl[i].eir});
            chk($sformatf("vec%0d_rf_we", i), {31'b0, bus.rf_we}, {31'b0, tbl[i].ewe});
            chk($sformatf("vec%0d_pending", i), bus.pending, tbl[i].epend);
            if (tbl[i].ewe) begin
                chk($sformatf("vec%0d_rf_waddr", i), {27'b0, bus.rf_waddr}, {27'b0, tbl[i].ewaddr});
                chk($sformatf("vec%0d_rf_wdata", i), bus.rf_wdata, tbl[i].ewdata);
            end
        end

        // Reset while an ALU grant and a pending register are in flight; last winner was LSU.
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 10);
        #1;
        chk("mid_issue_ready", {31'b0, bus.issue_ready}, 32'd1);
        @(negedge clk);
        drive(1, 9, 32'h99, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        chk("mid_pending_before", bus.pending, 32'h400);
        chk("mid_alu_ready", {31'b0, bus.alu_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        idle();
        #1;
        chk("mid_rf_we_t1", {31'b0, bus.rf_we}, 32'd0);
        chk("mid_pending", bus.pending, 32'd0);
        @(negedge clk);
        drive(1, 1, 32'hA1, 1, 2, 32'hB2, 0, 0, 0, 0, 0);
        #1;
        chk("mid_rf_we_t2", {31'b0, bus.rf_we}, 32'd0);
        chk("mid_conflict_lsu", {31'b0, bus.lsu_ready}, 32'd1);
        chk("mid_conflict_alu", {31'b0, bus.alu_ready}, 32'd0);
        @(negedge clk);
        idle();
        #1;
        chk("mid_rf_waddr", {27'b0, bus.rf_waddr}, 32'd2);
        chk("mid_rf_wdata", bus.rf_wdata, 32'hB2);

        // Randomized run from a fresh reset; requesters hold until granted.
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        a_hold = 1'b0;
        l_hold = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!a_hold) begin
                bus.alu_valid = ($urandom_range(0, 2) != 0);
                bus.alu_rd    = 5'($urandom_range(0, 7));
                bus.alu_data  = $urandom;
            end
            if (!l_hold) begin
                bus.lsu_valid = ($urandom_range(0, 2) != 0);
                bus.lsu_rd    = 5'($urandom_range(0, 7));
                bus.lsu_data  = $urandom;
            end
            bus.issue_valid = $urandom_range(0, 1) != 0;
            bus.issue_wen   = $urandom_range(0, 3) != 0;
            bus.issue_rs1   = 5'($urandom_range(0, 7));
            bus.issue_rs2   = 5'($urandom_range(0, 7));
            bus.issue_rd    = 5'($urandom_range(0, 7));
            #1;
            model_cycle(ga, gl);
            a_hold = bus.alu_valid && !ga;
            l_hold = bus.lsu_valid && !gl;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ysyx_25030085_rf_wb_sched.md
Name: ysyx_25030085_rf_wb_sched

Overview:
Writeback scheduler and scoreboard for the single-write-port register file. Two writeback requesters share the one write port: the ALU path (EXU) and the load-return path (LSU). The block arbitrates between them and drives a registered write port. A per-register pending bitmap stalls issue on RAW and WAW hazards. It sits between issue/EXU/LSU and the regfile write port.

Parameters:
XLEN, 32, data width
NREG, 32, number of architectural registers; x0 is hardwired zero
AW, 5, register address width, log2(NREG)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low (0 = reset)
issue_valid  in  1  decoder presents an instruction this cycle
issue_ready  out  1  instruction may issue (no hazard)
issue_rs1  in  AW  source register 1
issue_rs2  in  AW  source register 2
issue_rd  in  AW  destination register
issue_wen  in  1  instruction writes rd
alu_valid  in  1  ALU writeback request
alu_ready  out  1  ALU request granted this cycle
alu_rd  in  AW  ALU destination
alu_data  in  XLEN  ALU result
lsu_valid  in  1  load-return writeback request
lsu_ready  out  1  LSU request granted this cycle
lsu_rd  in  AW  load destination
lsu_data  in  XLEN  load data
rf_we  out  1  regfile write enable
rf_waddr  out  AW  regfile write address
rf_wdata  out  XLEN  regfile write data
pending  out  NREG  scoreboard bitmap, for debug/DPI

Behaviour:
- Reset (rst==0 at posedge): rf_we=0, rf_waddr=0, rf_wdata=0, pending=0, rr_last=ALU (LSU has priority on first conflict). Reset mid-operation discards in-flight grants and the pending write; no write occurs in the cycle after reset.
- Arbitration is combinational from the valids.
  - Only one valid: that requester's ready=1.
  - Both valid: round-robin. The requester not granted last conflict wins.
  - rr_last updates only on a conflict cycle.
  - ready never depends on the other side's ready.
  - Requesters hold valid/rd/data until ready.
- Write port: the granted request is registered into rf_we/rf_waddr/rf_wdata at the next posedge. Latency grant T, rf_we high during T+1, regfile holds the value from T+2.
  - A granted request with rd==0 is accepted (ready=1) but produces rf_we=0.
  - With no grant, rf_we=0 next cycle. rf_waddr/rf_wdata hold their previous values.
- Scoreboard set: fires when issue_valid & issue_ready & issue_wen & issue_rd!=0. pending[issue_rd] is set at the posedge.
- Scoreboard clear: fires when rf_we is high in cycle T+1. pending[rf_waddr] clears at the end of that cycle, which is the same edge at which the regfile writes.
- Set and clear of the same register on the same edge: set wins.
- pending[0] is constant 0.
- issue_ready = !(pending[rs1] | pending[rs2] | (issue_wen & pending[rd])). This stalls RAW and WAW.
  - Index 0 never stalls.
  - There is no bypass. A consumer stalls until the cycle after the regfile write edge, then reads the new value.
- issue_ready is combinational from pending and the issue fields, and does not depend on issue_valid.
- Writebacks arriving for a non-pending register are still written. The scoreboard clear is then a no-op.

Decomposition:
- Package ysyx_25030085_rf_pkg holds XLEN, NREG, AW, and the requester-id enum {REQ_ALU, REQ_LSU}.
- Natural sub-module: ysyx_25030085_rr_arb2, a 2-way round-robin arbiter with valid0/1 in, grant0/1 out, and its own rr_last flop.
- Scoreboard and the output register stay in the top module.

Test Plan:
1. Reset then idle, rst=0 for 2 cycles with all valids 0 -> rf_we=0, pending=0, issue_ready=1 for any rs/rd.
2. ALU only: alu_valid=1, alu_rd=5, alu_data=0x12345678 at T -> alu_ready=1 at T; rf_we=1, rf_waddr=5, rf_wdata=0x12345678 at T+1; rf_we=0 at T+2.
3. RAW stall: issue rd=7 (issue_wen=1) accepted at T, then an instruction with rs1=7 -> issue_ready=0. Then lsu_valid with rd=7, data=0xDEADBEEF granted at T+3 -> rf_we at T+4, pending[7] clears, issue_ready=1 at T+5.
4. Conflict round-robin: both valid for 3 consecutive cycles (alu_rd=1, lsu_rd=2, each holding until granted, then re-presenting) -> grants LSU, ALU, LSU. rf_waddr sequence 2, 1, 2.
5. Edge cases: (a) a grant with rd=0 gives ready=1 and rf_we=0 next cycle. (b) The same-edge clear of rd=3 and new issue of rd=3 leaves pending[3]=1. (c) WAW: issue rd=3 while pending[3]=1 -> issue_ready=0.
6. Reset mid-operation: alu granted at T, rst=0 at T+1 -> rf_we=0 at T+1 and T+2, pending=0, rr_last back to ALU, so LSU wins the next conflict.
